dinterp_cmd_sched: RTL and testbench
====================================

// Module: dinterp_cmd_sched
// PURPOSE
//  Arbitrates NUM_REQ command sources (e.g. SPI slave, host bridge) onto the single 32-bit command port of DINTERP.
//  Issues DATA/DATA_READY with the required settle timing: DINTERP raises WCLK 3 cycles after DATA_READY falls.
//  Returns a completion, plus read data for register-read commands (bit31=0), to the granted requester.
// PARAMETERS
//  NUM_REQ        2   number of requesters (2..4)
//  SETTLE_CYCLES  4   cycles DATA is held after the DATA_READY pulse; must be >=4, else elaboration $error
//  RD_WAIT        2   cycles after SETTLE before RDATA_IN is sampled (read commands only), >=1
//  DATAWIDTH      16  read-data width
// PORTS
//  clk         in   1               system clock, rising edge
//  rst_n       in   1               asynchronous active-low reset
//  REQ_VALID   in   NUM_REQ         per-requester command valid; held until REQ_READY
//  REQ_CMD     in   NUM_REQ*32      per-requester command word; slice i = [32*i+31:32*i]
//  REQ_READY   out  NUM_REQ         accept strobe; transfer on the edge where VALID&READY
//  RSP_VALID   out  NUM_REQ         one-cycle completion pulse to the owning requester
//  RSP_DATA    out  DATAWIDTH       read data, valid with RSP_VALID; 0 for writes
//  DATA        out  32              command word to DINTERP
//  DATA_READY  out  1               one-cycle command strobe to DINTERP
//  RDATA_IN    in   DATAWIDTH       read data returned from the register/wave bank
//  GRANT       out  NUM_REQ         one-hot owner of the in-flight command; 0 when idle
//  BUSY        out  1               high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer 0. Applies immediately on rst_n low, including mid-command.
//  After reset, no RSP_VALID for the aborted command; the next request is served normally.
//  FSM: IDLE -> ISSUE -> SETTLE -> (READ if cmd[31]==0) -> DONE -> IDLE.
//  IDLE: arbiter picks g among REQ_VALID. REQ_READY[g] is driven combinationally; all other bits are 0.
//    On that edge: latch REQ_CMD slice g, GRANT<=onehot(g), go to ISSUE. With no REQ_VALID, stay in IDLE.
//  ISSUE (1 cycle): DATA=cmd, DATA_READY=1.
//  SETTLE: DATA_READY=0, DATA held, runs exactly SETTLE_CYCLES cycles (counter).
//  READ: RD_WAIT cycles. RDATA_IN is registered at the end of the last READ cycle.
//  DONE (1 cycle): RSP_VALID[g]=1, RSP_DATA = captured data (read) or 0 (write).
//    Then GRANT<=0 and IDLE at the next edge.
//  Latency from accept edge: write RSP_VALID in cycle SETTLE_CYCLES+2; read in SETTLE_CYCLES+RD_WAIT+2.
//  Throughput: one command per SETTLE_CYCLES+3 (write) cycles; no pipelining, no queueing.
//  DATA keeps its last value after DONE. Only ISSUE changes it.
//  REQ_READY is 0 outside IDLE. A requester raising VALID while BUSY waits.
//  A requester dropping VALID after accept has no effect on the in-flight command.
//  RSP_DATA holds its value until the next DONE.
//  Simultaneous VALIDs in IDLE: exactly one grant per arbitration (see CONFIGURATION).
// CONFIGURATION
//  SCHED_RR_EN defined: round-robin arbitration.
//    The search starts at index (last granted + 1) mod NUM_REQ.
//    The pointer updates only on accept and resets to 0.
//  SCHED_RR_EN undefined: fixed priority, lowest index wins. The pointer logic is absent.
// TESTING
//  1 rst_n=0 with clk running -> DATA=0, DATA_READY=0, REQ_READY=0, RSP_VALID=0, GRANT=0, BUSY=0.
//  2 REQ_VALID=01, REQ_CMD[0]=32'hCA33A3A3 -> REQ_READY=01 same cycle, then DATA_READY=1 for 1 cycle.
//    DATA=CA33A3A3 held 5 cycles; RSP_VALID=01 in cycle 6; RSP_DATA=0.
//  3 REQ_VALID=10, REQ_CMD[1]=32'h0040A4A4, RDATA_IN=16'h1234 -> RSP_VALID=10 in cycle 8, RSP_DATA=16'h1234.
//  4 REQ_VALID=11 held for 4 commands -> with SCHED_RR_EN, grants 0,1,0,1; without it, grants 0,0,0,0.
//  5 rst_n low during SETTLE of req0 -> outputs 0 immediately, no RSP_VALID.
//    After release, a req1 write completes in 6 cycles.
//  6 REQ_VALID[1] raised 2 cycles into a req0 command -> REQ_READY[1]=0 until IDLE.
//    req1 is accepted on the first IDLE cycle after DONE.

Source files
------------

// File: rtl/dinterp_cmd_sched.sv
// Multi-requester command scheduler for the DINTERP 32-bit command port.
// Define SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module dinterp_cmd_sched #(
  parameter int NUM_REQ       = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int RD_WAIT       = 2,
  parameter int DATAWIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  input  logic [NUM_REQ*32-1:0]  REQ_CMD,
  output logic [NUM_REQ-1:0]     REQ_READY,
  output logic [NUM_REQ-1:0]     RSP_VALID,
  output logic [DATAWIDTH-1:0]   RSP_DATA,
  output logic [31:0]            DATA,
  output logic                   DATA_READY,
  input  logic [DATAWIDTH-1:0]   RDATA_IN,
  output logic [NUM_REQ-1:0]     GRANT,
  output logic                   BUSY
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + RD_WAIT + 1);

  if (SETTLE_CYCLES < 4) begin : g_chk_settle
    $error("SETTLE_CYCLES must be >= 4");
  end
  if (RD_WAIT < 1) begin : g_chk_rdwait
    $error("RD_WAIT must be >= 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_chk_nreq
    $error("NUM_REQ must be 2..4");
  end

  typedef enum logic [2:0] {
    IDLE, ISSUE, SETTLE, READ, DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [GW-1:0]  sel;
  logic           found;

`ifdef SCHED_RR_EN
  logic [GW-1:0]  ptr;
`endif

  always_comb begin
    int j;
    j     = 0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SCHED_RR_EN
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
`else
      j = k;
`endif
      if (!found && REQ_VALID[j]) begin
        found = 1'b1;
        sel   = GW'(j);
      end
    end
  end

  assign REQ_READY = (state == IDLE && found)
                   ? (NUM_REQ'(1) << sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      DATA       <= '0;
      DATA_READY <= 1'b0;
      GRANT      <= '0;
      BUSY       <= 1'b0;
      RSP_VALID  <= '0;
      RSP_DATA   <= '0;
`ifdef SCHED_RR_EN
      ptr        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            DATA       <= REQ_CMD[32*sel +: 32];
            DATA_READY <= 1'b1;
            GRANT      <= NUM_REQ'(1) << sel;
            BUSY       <= 1'b1;
            state      <= ISSUE;
`ifdef SCHED_RR_EN
            ptr <= (sel == GW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
`endif
          end
        end
        ISSUE: begin
          DATA_READY <= 1'b0;
          cnt        <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES-1)) begin
            cnt <= '0;
            // bit31 clear marks a register read
            if (!DATA[31]) begin
              state <= READ;
            end else begin
              RSP_VALID <= GRANT;
              RSP_DATA  <= '0;
              state     <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          if (cnt == CW'(RD_WAIT-1)) begin
            RSP_DATA  <= RDATA_IN;
            RSP_VALID <= GRANT;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          RSP_VALID <= '0;
          GRANT     <= '0;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dinterp_cmd_sched.sv
// Directed testbench for dinterp_cmd_sched (default parameters).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_dinterp_cmd_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  REQ_VALID;
  logic [63:0] REQ_CMD;
  logic [1:0]  REQ_READY;
  logic [1:0]  RSP_VALID;
  logic [15:0] RSP_DATA;
  logic [31:0] DATA;
  logic        DATA_READY;
  logic [15:0] RDATA_IN;
  logic [1:0]  GRANT;
  logic        BUSY;

  int total;
  int bad;

  dinterp_cmd_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .REQ_VALID  (REQ_VALID),
    .REQ_CMD    (REQ_CMD),
    .REQ_READY  (REQ_READY),
    .RSP_VALID  (RSP_VALID),
    .RSP_DATA   (RSP_DATA),
    .DATA       (DATA),
    .DATA_READY (DATA_READY),
    .RDATA_IN   (RDATA_IN),
    .GRANT      (GRANT),
    .BUSY       (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    REQ_VALID = '0;
    REQ_CMD = '0;
    RDATA_IN = '0;
    tick(3);
    total++;
    if ({DATA, DATA_READY, REQ_READY, RSP_VALID, GRANT, BUSY} !== '0) begin
      bad++;
      $display("FAIL reset_outs got DATA=%h DR=%b RDY=%b RV=%b G=%b B=%b exp all 0",
               DATA, DATA_READY, REQ_READY, RSP_VALID, GRANT, BUSY);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_write;
    int err;
    REQ_CMD[31:0] = 32'hCA33A3A3;
    REQ_VALID = 2'b01;
    #1;
    total++;
    if (REQ_READY !== 2'b01) begin
      bad++;
      $display("FAIL wr_ready got=%b exp=01", REQ_READY);
    end
    tick(1);
    REQ_VALID = '0;
    total++;
    if ({DATA_READY, DATA, GRANT, BUSY} !== {1'b1, 32'hCA33A3A3, 2'b01, 1'b1}) begin
      bad++;
      $display("FAIL wr_issue got DR=%b DATA=%h G=%b B=%b exp 1 CA33A3A3 01 1",
               DATA_READY, DATA, GRANT, BUSY);
    end
    err = 0;
    for (int c = 2; c <= 5; c++) begin
      tick(1);
      if (DATA_READY !== 1'b0 || DATA !== 32'hCA33A3A3 || RSP_VALID !== 2'b00)
        err++;
    end
    total++;
    if (err != 0) begin
      bad++;
      $display("FAIL wr_settle got=%0d bad cycles exp=0", err);
    end
    tick(1);
    total++;
    if (RSP_VALID !== 2'b01 || RSP_DATA !== 16'h0) begin
      bad++;
      $display("FAIL wr_rsp got RV=%b RD=%h exp 01 0000", RSP_VALID, RSP_DATA);
    end
    tick(1);
    total++;
    if ({RSP_VALID, GRANT, BUSY} !== 5'b0 || DATA !== 32'hCA33A3A3) begin
      bad++;
      $display("FAIL wr_idle got RV=%b G=%b B=%b DATA=%h exp 00 00 0 CA33A3A3",
               RSP_VALID, GRANT, BUSY, DATA);
    end
  endtask

  task automatic test_read;
    REQ_CMD[63:32] = 32'h0040A4A4;
    RDATA_IN = 16'h1234;
    REQ_VALID = 2'b10;
    #1;
    total++;
    if (REQ_READY !== 2'b10) begin
      bad++;
      $display("FAIL rd_ready got=%b exp=10", REQ_READY);
    end
    tick(1);
    REQ_VALID = '0;
    tick(6);
    total++;
    if (RSP_VALID !== 2'b00 || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL rd_c7 got RV=%b B=%b exp 00 1", RSP_VALID, BUSY);
    end
    tick(1);
    RDATA_IN = 16'hFFFF;
    total++;
    if (RSP_VALID !== 2'b10 || RSP_DATA !== 16'h1234) begin
      bad++;
      $display("FAIL rd_rsp got RV=%b RD=%h exp 10 1234", RSP_VALID, RSP_DATA);
    end
    tick(1);
    total++;
    if (RSP_VALID !== 2'b00 || RSP_DATA !== 16'h1234 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL rd_hold got RV=%b RD=%h B=%b exp 00 1234 0",
               RSP_VALID, RSP_DATA, BUSY);
    end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_g [4];
    logic [31:0] exp_d;
    bit hit;
`ifdef SCHED_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    REQ_CMD = {32'h8000_0002, 32'h8000_0001};
    REQ_VALID = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      hit = 1'b0;
      for (int w = 0; w < 20 && !hit; w++) begin
        if (REQ_READY !== 2'b00) hit = 1'b1;
        else begin
          tick(1);
          #1;
        end
      end
      total++;
      if (!hit || REQ_READY !== exp_g[n]) begin
        bad++;
        $display("FAIL arb_ready%0d got=%b exp=%b", n, REQ_READY, exp_g[n]);
      end
      tick(1);
      exp_d = (exp_g[n] == 2'b01) ? 32'h8000_0001 : 32'h8000_0002;
      if (n == 3) REQ_VALID = '0;
      total++;
      if (GRANT !== exp_g[n] || DATA !== exp_d) begin
        bad++;
        $display("FAIL arb_grant%0d got G=%b DATA=%h exp %b %h",
                 n, GRANT, DATA, exp_g[n], exp_d);
      end
      #1;
    end
    tick(6);
  endtask

  task automatic test_reset_mid;
    int rv;
    REQ_CMD[31:0] = 32'h8000_00AA;
    REQ_VALID = 2'b01;
    tick(1);
    REQ_VALID = '0;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({DATA, DATA_READY, REQ_READY, RSP_VALID, GRANT, BUSY} !== '0) begin
      bad++;
      $display("FAIL rst_mid got DATA=%h G=%b B=%b RV=%b exp all 0",
               DATA, GRANT, BUSY, RSP_VALID);
    end
    tick(2);
    rst_n = 1'b1;
    rv = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (RSP_VALID !== 2'b00) rv++;
    end
    total++;
    if (rv != 0) begin
      bad++;
      $display("FAIL rst_no_rsp got=%0d pulses exp=0", rv);
    end
    REQ_CMD[63:32] = 32'h8000_00BB;
    REQ_VALID = 2'b10;
    tick(1);
    REQ_VALID = '0;
    tick(4);
    total++;
    if (RSP_VALID !== 2'b00) begin
      bad++;
      $display("FAIL rst_c5 got RV=%b exp=00", RSP_VALID);
    end
    tick(1);
    total++;
    if (RSP_VALID !== 2'b10 || RSP_DATA !== 16'h0) begin
      bad++;
      $display("FAIL rst_after got RV=%b RD=%h exp 10 0000", RSP_VALID, RSP_DATA);
    end
    tick(1);
  endtask

  task automatic test_back_to_back;
    int err;
    REQ_CMD = {32'h8000_0022, 32'h8000_0011};
    REQ_VALID = 2'b01;
    tick(1);
    REQ_VALID = '0;
    tick(1);
    REQ_VALID = 2'b10;
    err = 0;
    for (int c = 2; c <= 6; c++) begin
      #1;
      if (REQ_READY !== 2'b00) err++;
      if (c < 6) tick(1);
    end
    total++;
    if (err != 0 || RSP_VALID !== 2'b01) begin
      bad++;
      $display("FAIL b2b_wait got=%0d early readies RV=%b exp 0 01", err, RSP_VALID);
    end
    tick(1);
    #1;
    total++;
    if (REQ_READY !== 2'b10 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready got RDY=%b B=%b exp 10 0", REQ_READY, BUSY);
    end
    tick(1);
    REQ_VALID = '0;
    total++;
    if (GRANT !== 2'b10 || DATA !== 32'h8000_0022 || DATA_READY !== 1'b1) begin
      bad++;
      $display("FAIL b2b_grant got G=%b DATA=%h DR=%b exp 10 80000022 1",
               GRANT, DATA, DATA_READY);
    end
    tick(7);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_write;
    test_read;
    test_arbitration;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
